spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI peripheral (target) end of the team's SPI link, the counterpart of the SPI master core.
- Runs on the system clock and oversamples the externally driven sclk, ss_n and mosi.
- Receives one byte per 8 sclk cycles and shifts out a byte that the host preloads.
- Supports all four cpol/cpha modes and back-to-back bytes within one ss_n assertion.

Parameters:
- TX_IDLE, 8'hFF, byte shifted out when the host has not loaded a tx byte (underrun).
- SYNC_STAGES, 2, synchronizer depth on sclk, ss_n and mosi (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpol  input  1  sclk idle level; must be stable while ss_n is low
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; stable while ss_n is low
- din  input  8  tx byte, written to the tx buffer on tx_wr
- tx_wr  input  1  one-cycle write strobe for din
- tx_ready  output  1  tx buffer empty
- dout  output  8  last complete received byte
- rx_done_tick  output  1  one-cycle pulse when dout is updated
- tx_underrun_tick  output  1  one-cycle pulse when TX_IDLE is loaded instead of buffer data
- busy  output  1  state is ACTIVE
- sclk  input  1  SPI clock from the master (asynchronous)
- ss_n  input  1  active-low select (asynchronous)
- mosi  input  1  serial data in (asynchronous)
- miso  output  1  serial data out, equal to so_reg[7]
- miso_oe  output  1  miso tri-state enable, equal to busy

Behaviour:
- Reset values:
  - state IDLE
  - so_reg, si_reg, dout and bit count n all 0
  - tx_buf 0, tx_full 0 (tx_ready=1)
  - all ticks 0, miso_oe 0
  - ss_n synchronizer stages set to 1; sclk and mosi synchronizer stages set to 0
- Synchronizers: sclk, ss_n and mosi each pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d
  - leading = cpol ? fall : rise; trailing = cpol ? rise : fall
  - sample edge = cpha ? trailing : leading; drive edge = the other one
- Timing requirement: each sclk phase lasts at least SYNC_STAGES+2 clk cycles (master dvsr ≥ 3 with defaults). miso changes SYNC_STAGES+1 clk edges after the sclk pin edge.
- Tx source (used on every "load"):
  - If tx_full: use tx_buf and clear tx_full.
  - Else: use TX_IDLE and pulse tx_underrun_tick.
  - If tx_wr arrives in the same cycle as a load: the load takes the old content (or TX_IDLE), then tx_buf <= din and tx_full=1.
- tx_wr when tx_full=1 overwrites tx_buf; no error is flagged.
- FSM IDLE:
  - sclk edges are ignored; miso_oe=0.
  - On synced ss_n falling: n=0, go to ACTIVE; if cpha=0, load so_reg.
- FSM ACTIVE:
  - Sample edge: si_reg <= {si_reg[6:0], mosi_s}; n <= n+1 (3-bit, wraps).
  - When n==7 at a sample edge: dout <= {si_reg[6:0], mosi_s} and rx_done_tick=1 in the next cycle.
  - Drive edge: if n==0, load so_reg; else so_reg <= {so_reg[6:0], 1'b0}.
  - With cpha=0, the drive edge after the 8th sample presents the next byte's MSB. With cpha=1, the first leading edge of each byte loads it.
- ss_n synced rising, at any point including mid-byte: go to IDLE next cycle and set n=0.
  - A partial byte is discarded; no rx_done_tick.
  - dout and tx_buf are untouched.
  - A byte already loaded into so_reg is lost (consumed).
- An ss_n edge and an sclk edge in the same cycle: ss_n wins; the sclk edge is ignored.
- cpol/cpha changes while busy are undefined; the bench does not exercise them.

Test Plan:
- Mode 0 (cpol=0, cpha=0), sclk phase 8 clk:
  - Preload din=8'hA5; master sends 8'h3C.
  - Required: miso bits 1,0,1,0,0,1,0,1; dout=8'h3C; exactly one rx_done_tick; tx_ready back to 1 after ss_n falls.
- Modes 1, 2 and 3, same bytes: identical dout and miso bit sequence; each miso bit is stable across the master's sample edge.
- Two bytes under one ss_n:
  - Preload 8'h11; write 8'h22 after the first load; master sends 8'hF0 then 8'h0F.
  - Required: miso 8'h11 then 8'h22; two rx_done_ticks; dout ends at 8'h0F; no underrun.
- Underrun: no preload, 1 byte in mode 0 -> tx_underrun_tick once; miso shifts 8'hFF.
- Abort: ss_n rises after 5 sclk cycles -> no rx_done_tick; dout unchanged; busy=0 within SYNC_STAGES+2 cycles. The next full transfer of 8'h5A gives dout=8'h5A.
- Reset mid-byte (reset asserted at bit 3) -> all outputs at reset values immediately; sclk edges while ss_n is high produce no activity.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target with a one-byte tx buffer, all four cpol/cpha modes
module spi_slave #(
  parameter logic [7:0] TX_IDLE = 8'hFF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] din,
  input  logic       tx_wr,
  output logic       tx_ready,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       tx_underrun_tick,
  output logic       busy,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic rise, fall, lead, trail, samp, drv, ss_fall, ss_rise, load;
  logic [7:0] so_reg, so_next, si_reg, si_next, dout_next, tx_buf, tx_buf_next, tx_src;
  logic [2:0] n, n_next;
  logic tx_full, tx_full_next, rx_done_next, under_next;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign lead    = cpol ? fall : rise;
  assign trail   = cpol ? rise : fall;
  assign samp    = cpha ? trail : lead;
  assign drv     = cpha ? lead : trail;
  assign ss_fall = ~ss_s & ss_d;
  assign ss_rise = ss_s & ~ss_d;
  assign tx_src  = tx_full ? tx_buf : TX_IDLE;

  assign tx_ready = ~tx_full;
  assign busy     = state == ACTIVE;
  assign miso     = so_reg[7];
  assign miso_oe  = busy;

  // bring the asynchronous pins into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end

  // next-state: select edges drive the FSM and win over any simultaneous sclk edge
  always_comb begin
    state_next   = state;
    so_next      = so_reg;
    si_next      = si_reg;
    n_next       = n;
    dout_next    = dout;
    rx_done_next = 1'b0;
    load         = 1'b0;
    if (state == IDLE) begin
      if (ss_fall) begin
        state_next = ACTIVE;
        n_next     = 3'd0;
        load       = ~cpha;
      end
    end else if (ss_rise) begin
      state_next = IDLE;
      n_next     = 3'd0;
    end else if (samp) begin
      si_next = {si_reg[6:0], mosi_s};
      n_next  = n + 3'd1;
      if (n == 3'd7) begin
        dout_next    = {si_reg[6:0], mosi_s};
        rx_done_next = 1'b1;
      end
    end else if (drv) begin
      if (n == 3'd0) load = 1'b1;
      else so_next = {so_reg[6:0], 1'b0};
    end
    if (load) so_next = tx_src;
    tx_full_next = tx_wr | (tx_full & ~load);
    tx_buf_next  = tx_wr ? din : tx_buf;
    under_next   = load & ~tx_full;
  end

  // state, shift registers, tx buffer and output ticks
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state            <= IDLE;
      so_reg           <= 8'd0;
      si_reg           <= 8'd0;
      dout             <= 8'd0;
      n                <= 3'd0;
      tx_buf           <= 8'd0;
      tx_full          <= 1'b0;
      rx_done_tick     <= 1'b0;
      tx_underrun_tick <= 1'b0;
    end else begin
      state            <= state_next;
      so_reg           <= so_next;
      si_reg           <= si_next;
      dout             <= dout_next;
      n                <= n_next;
      tx_buf           <= tx_buf_next;
      tx_full          <= tx_full_next;
      rx_done_tick     <= rx_done_next;
      tx_underrun_tick <= under_next;
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving an SPI master model into spi_slave
module tb_spi_slave;
  localparam int H = 8;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, tx_wr = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [7:0] din = 8'd0;
  logic tx_ready, rx_done_tick, tx_underrun_tick, busy, miso, miso_oe;
  logic [7:0] dout;
  int checks = 0, failures = 0, und_cnt = 0;
  logic [7:0] exp_rx[$];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .din(din), .tx_wr(tx_wr),
    .tx_ready(tx_ready), .dout(dout), .rx_done_tick(rx_done_tick),
    .tx_underrun_tick(tx_underrun_tick), .busy(busy), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // monitor: every received byte must match the oldest expected one
  always @(negedge clk) begin
    if (tx_underrun_tick) und_cnt++;
    if (rx_done_tick) begin
      if (exp_rx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rx_done: dout=%h with nothing expected", dout);
      end else chk8("dout", dout, exp_rx.pop_front());
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    din = d;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic a);
    cpol = p;
    cpha = a;
    sclk = p;
    repeat (H) @(negedge clk);
  endtask

  task automatic idle_chk(input string name);
    chk1({name, "_busy"}, busy, 1'b0);
    chk1({name, "_miso_oe"}, miso_oe, 1'b0);
    chk1({name, "_tx_ready"}, tx_ready, 1'b1);
    chk8({name, "_dout"}, dout, 8'h00);
    chk1({name, "_miso"}, miso, 1'b0);
    chk1({name, "_rx_done"}, rx_done_tick, 1'b0);
    chk1({name, "_underrun"}, tx_underrun_tick, 1'b0);
  endtask

  // master model: nbits bits MSB first from mo, expects mi on miso, one ss_n assertion
  task automatic xfer(input int nbits, input logic [15:0] mo, input logic [15:0] mi);
    logic m;
    ss_n = 1'b0;
    if (!cpha) mosi = mo[15];
    repeat (H) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (cpha) begin
        sclk = ~cpol;
        mosi = mo[15-k];
        repeat (H) @(negedge clk);
      end
      m = miso;
      chk1("miso_bit", m, mi[15-k]);
      sclk = ~sclk;
      repeat (4) @(negedge clk);
      chk1("miso_hold", miso, m);
      repeat (H - 4) @(negedge clk);
      if (!cpha) begin
        sclk = cpol;
        if (k == nbits - 1) ss_n = 1'b1;
        else begin
          mosi = mo[14-k];
          repeat (H) @(negedge clk);
        end
      end
    end
    ss_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
    chk1("busy_after_ss", busy, 1'b0);
    repeat (H) @(negedge clk);
    mosi = 1'b0;
  endtask

  task automatic drained(input string name);
    chk8(name, 8'(exp_rx.size()), 8'd0);
  endtask

  initial begin
    int u0;
    repeat (3) @(negedge clk);
    idle_chk("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int md = 0; md < 4; md++) begin
      set_mode(md[1], md[0]);
      u0 = und_cnt;
      wr(8'hA5);
      chk1("preload_tx_ready", tx_ready, 1'b0);
      exp_rx.push_back(8'h3C);
      xfer(8, 16'h3C00, 16'hA500);
      chk1("mode_tx_ready", tx_ready, 1'b1);
      chk8("mode_dout", dout, 8'h3C);
      chk8("mode_underruns", 8'(und_cnt - u0), 8'd0);
      drained("mode_rx_count");
    end

    set_mode(1'b0, 1'b0);
    u0 = und_cnt;
    wr(8'h11);
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    fork
      xfer(16, 16'hF00F, 16'h1122);
      begin
        repeat (10) @(negedge clk);
        wr(8'h22);
      end
    join
    chk8("two_byte_dout", dout, 8'h0F);
    chk8("two_byte_underruns", 8'(und_cnt - u0), 8'd0);
    chk1("two_byte_tx_ready", tx_ready, 1'b1);
    drained("two_byte_rx_count");

    u0 = und_cnt;
    exp_rx.push_back(8'h96);
    xfer(8, 16'h9600, 16'hFF00);
    chk8("underrun_count", 8'(und_cnt - u0), 8'd1);
    chk8("underrun_dout", dout, 8'h96);
    drained("underrun_rx_count");

    xfer(5, 16'hC300, 16'hF800);
    chk8("abort_dout", dout, 8'h96);
    drained("abort_rx_count");
    wr(8'hC3);
    exp_rx.push_back(8'h5A);
    xfer(8, 16'h5A00, 16'hC300);
    chk8("after_abort_dout", dout, 8'h5A);
    drained("after_abort_rx_count");

    u0 = und_cnt;
    wr(8'h77);
    ss_n = 1'b0;
    mosi = 1'b1;
    repeat (H) @(negedge clk);
    wr(8'h88);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      repeat (H) @(negedge clk);
    end
    chk1("mid_byte_busy", busy, 1'b1);
    chk1("mid_byte_tx_ready", tx_ready, 1'b0);
    reset = 1'b1;
    #1;
    idle_chk("mid_reset");
    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      repeat (H) @(negedge clk);
    end
    idle_chk("post_reset");
    chk8("post_reset_underruns", 8'(und_cnt - u0), 8'd0);
    drained("post_reset_rx_count");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
